lcd_dma_8080: RTL and testbench
===============================

// Module: lcd_dma_8080
// PURPOSE
//  Avalon-MM LCD controller for 8080-style parallel panels (ILI93xx class), successor to the fixed 16-bit LCD port.
//  Host queues command/data words through a slave register file. A DMA master streams LEN pixels from SDRAM into a FIFO.
//  A timing FSM with programmable strobe widths drains the FIFO onto the panel bus. Raises irq when a frame completes.
// PARAMETERS
//  DATA_W       16   panel bus width (8/16/18); one FIFO/DMA word per panel write
//  FIFO_DEPTH   16   entries, power of 2, >=4; entry = {dc, data}
//  ADDR_W       32   DMA byte-address width
//  LEN_W        24   DMA length counter width (words)
//  WR_LOW_CYC   2    clk cycles lcd_wr held low per write (>=1)
//  WR_HIGH_CYC  2    clk cycles lcd_wr held high after each write (>=1)
// PORTS
//  clk              in   1        single clock, all logic rising-edge
//  reset_n          in   1        synchronous, active-low reset
//  avs_address      in   3        reg select: 0 CMD,1 DATA,2 DMA_ADDR,3 DMA_LEN,4 CTRL,5 STATUS
//  avs_write        in   1        slave write
//  avs_writedata    in   32       slave write data
//  avs_read         in   1        slave read
//  avs_readdata     out  32       read data, valid 1 cycle after avs_read
//  avs_waitrequest  out  1        stalls CMD/DATA writes (see below); 0 for all other accesses
//  avm_address      out  ADDR_W   DMA read address
//  avm_read         out  1        DMA read request
//  avm_waitrequest  in   1        master stall
//  avm_readdata     in   DATA_W   DMA read data
//  avm_readdatavalid in  1        pipelined read return
//  lcd_data         out  DATA_W   panel data bus
//  lcd_dc           out  1        0=command, 1=data
//  lcd_rd           out  1        read strobe, constant 1
//  lcd_wr           out  1        write strobe, panel latches on rising edge
//  lcd_reset_n      out  1        panel reset, = CTRL[2]
//  irq              out  1        = done & irq_en
// BEHAVIOUR
//  Reset: all outputs 0 except lcd_wr=1, lcd_rd=1; lcd_reset_n=0; FIFO empty; DMA_ADDR=DMA_LEN=0; CTRL=0; done=0.
//  Registers: CMD/DATA write pushes {0/1, wd[DATA_W-1:0]}. DMA_ADDR, DMA_LEN[LEN_W-1:0] R/W.
//   CTRL: bit0 start (write 1, self-clearing, reads 0), bit1 irq_en, bit2 lcd_reset_n.
//   STATUS (RO except W1C): bit0 busy, bit1 done (write 1 clears), bit2 fifo_empty, bit3 fifo_full. Undefined addrs read 0.
//  Waitrequest: CMD/DATA write stalls while FIFO full or DMA busy; it completes in the first cycle neither holds.
//  DMA: start with busy=0 -> busy=1, rd_addr=DMA_ADDR, remaining=DMA_LEN, done cleared. start while busy ignored.
//   Issue avm_read only if remaining>0 and fifo_count+outstanding < FIFO_DEPTH. Hold address/read while avm_waitrequest.
//   Per accepted read: addr += DATA_W/8, remaining -= 1, outstanding += 1. Each readdatavalid pushes {1,data}, outstanding -= 1.
//   FIFO can never overflow by construction; push and pop in the same cycle keeps the count unchanged.
//  Completion: remaining==0 and outstanding==0 and FIFO empty and writer IDLE -> busy=0, done=1 (same cycle).
//   DMA_LEN=0: start sets done one cycle later and issues no reads.
//  Writer FSM: IDLE -> (FIFO non-empty: pop, latch lcd_data/lcd_dc) SETUP -> LOW -> HIGH -> IDLE.
//   SETUP: 1 cycle, data/dc stable, wr=1. LOW: WR_LOW_CYC cycles, wr=0. HIGH: WR_HIGH_CYC cycles, wr=1.
//   lcd_data/lcd_dc hold their value until the next pop. One write = 1+WR_LOW_CYC+WR_HIGH_CYC cycles, plus 1 idle cycle.
//  Reset mid-operation: synchronous reset aborts DMA and writer immediately. lcd_wr returns to 1, the FIFO is flushed,
//   and in-flight readdatavalid beats after reset are discarded.
//  Simultaneous done-set and W1C clear in the same cycle: set wins.
// TESTING
//  1 Reset: after reset_n low 2 clk -> lcd_wr=1, lcd_rd=1, lcd_reset_n=0, irq=0, STATUS=0x4.
//  2 Write CMD=0x2C, then DATA=0x1234 -> two panel writes. dc=0 then 1, data 0x002C then 0x1234.
//    wr low exactly 2 cycles each, with 1+2+2 cycle spacing plus the idle cycle.
//  3 DMA_ADDR=0x100, LEN=40, irq_en=1, start; slave returns addr[15:0] with random waitrequest and random 0-5 cycle latency
//    -> 40 panel writes of 0x0100,0x0102,...; FIFO never exceeds 16; irq=1 after last wr rise; W1C done -> irq=0.
//  4 DMA_LEN=0, start -> no avm_read; done=1 next cycle; busy never observed 1 for more than 1 cycle.
//  5 CMD write during active DMA -> avs_waitrequest high until done. Then the word appears as the first write after the frame.
//  6 Reset asserted mid-frame with reads outstanding -> bus idle and FIFO empty; late readdatavalid is ignored; a fresh DMA runs correctly.

Source files
------------

// File: rtl/lcd_dma_8080.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lcd_dma_8080
// Description : Avalon-MM LCD controller for 8080-style parallel panels.
//               The host queues command/data words through a small slave
//               register file; a DMA read master streams DMA_LEN pixels from
//               memory into a shared FIFO; a write-strobe timing FSM drains
//               the FIFO onto the panel bus. irq is raised when a frame ends.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n        : single rising-edge clock, synchronous active-low reset
//   avs_*               : Avalon-MM slave (registers below, 32-bit data)
//                         0 CMD, 1 DATA, 2 DMA_ADDR, 3 DMA_LEN, 4 CTRL, 5 STATUS
//   avm_*               : Avalon-MM pipelined read master (DMA)
//   lcd_data, lcd_dc    : panel bus and data/command select (1 = data)
//   lcd_rd              : panel read strobe, tied inactive high
//   lcd_wr              : panel write strobe, panel latches on rising edge
//   lcd_reset_n         : panel reset, driven from CTRL[2]
//   irq                 : frame done AND irq enable
// ============================================================================
module lcd_dma_8080 #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 24,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    // Avalon-MM slave
    input  logic [2:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    // Avalon-MM read master
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    // Panel bus
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_dc,
    output logic              lcd_rd,
    output logic              lcd_wr,
    output logic              lcd_reset_n,
    output logic              irq
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [2:0] A_CMD      = 3'd0;
    localparam logic [2:0] A_DATA     = 3'd1;
    localparam logic [2:0] A_DMA_ADDR = 3'd2;
    localparam logic [2:0] A_DMA_LEN  = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(DATA_W / 8);
    localparam logic [TMR_W-1:0]  LOW_LOAD  = TMR_W'(WR_LOW_CYC - 1);
    localparam logic [TMR_W-1:0]  HIGH_LOAD = TMR_W'(WR_HIGH_CYC - 1);

    // Writer FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_HIGH  = 2'd3;

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] dma_addr_q;
    logic [LEN_W-1:0]  dma_len_q;
    logic              irq_en_q;
    logic              lcd_rst_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [31:0]       avs_readdata_q, rdata_d;

    // ------------------------------------------------------------------
    // DMA state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic              avm_read_q, avm_read_d;

    // ------------------------------------------------------------------
    // FIFO state; entry = {dc, data}
    // ------------------------------------------------------------------
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;
    logic              fifo_empty, fifo_full;
    logic              fifo_push, fifo_pop;
    logic [DATA_W:0]   push_entry, head_entry;

    // ------------------------------------------------------------------
    // Writer state
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              lcd_wr_q, wr_next;
    logic [DATA_W-1:0] lcd_data_q;
    logic              lcd_dc_q;

    // ------------------------------------------------------------------
    // Slave decode
    // ------------------------------------------------------------------
    logic host_fifo_wr, host_push, ctrl_wr, start_req, status_w1c;
    logic accept, beat, frame_end;
    logic space_ok;

    assign fifo_empty   = (fifo_count_q == '0);
    assign fifo_full    = (fifo_count_q == FULL_CNT);

    assign host_fifo_wr = avs_write && ((avs_address == A_CMD) || (avs_address == A_DATA));
    // CMD/DATA writes wait while the FIFO is full or a frame owns the FIFO,
    // so host words never interleave with pixel data.
    assign avs_waitrequest = host_fifo_wr && (fifo_full || busy_q);
    assign host_push    = host_fifo_wr && !fifo_full && !busy_q;

    assign ctrl_wr      = avs_write && (avs_address == A_CTRL);
    assign start_req    = ctrl_wr && avs_writedata[0] && !busy_q;
    assign status_w1c   = avs_write && (avs_address == A_STATUS) && avs_writedata[1];

    // ------------------------------------------------------------------
    // DMA master
    // ------------------------------------------------------------------
    assign accept = avm_read_q && !avm_waitrequest;
    // A return beat with nothing outstanding belongs to a read issued before
    // a reset; it is dropped.
    assign beat   = avm_readdatavalid && (outstanding_q != '0);

    // Host pushes only while idle and beats only arrive while busy, so the
    // two push sources never collide.
    assign fifo_push  = host_push || beat;
    assign push_entry = beat ? {1'b1, avm_readdata}
                             : {(avs_address == A_DATA), avs_writedata[DATA_W-1:0]};
    assign head_entry = fifo_mem[rd_ptr_q];

    assign frame_end = busy_q && (remaining_q == '0) && (outstanding_q == '0) &&
                       fifo_empty && (state_q == S_IDLE);

    always_comb begin
        fifo_count_d = fifo_count_q;
        if (fifo_push && !fifo_pop) begin
            fifo_count_d = fifo_count_q + CNT_W'(1);
        end else if (!fifo_push && fifo_pop) begin
            fifo_count_d = fifo_count_q - CNT_W'(1);
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !beat) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!accept && beat) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    // Space is judged on next-cycle occupancy, so a request that is raised
    // and then stalled still has a guaranteed FIFO slot when it is accepted.
    assign space_ok = ({1'b0, fifo_count_d} + {1'b0, outstanding_d}) < {1'b0, FULL_CNT};

    always_comb begin
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        if (start_req) begin
            rd_addr_d   = dma_addr_q;
            remaining_d = dma_len_q;
        end else if (accept) begin
            rd_addr_d   = rd_addr_q + ADDR_INC;
            remaining_d = remaining_q - LEN_W'(1);
        end
        if (avm_read_q && avm_waitrequest) begin
            avm_read_d = 1'b1;
        end else begin
            avm_read_d = busy_q && (remaining_d != '0) && space_ok;
        end
    end

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        if (start_req) begin
            busy_d = 1'b1;
        end else if (frame_end) begin
            busy_d = 1'b0;
        end
        // Setting done takes priority over a same-cycle W1C clear.
        if (frame_end) begin
            done_d = 1'b1;
        end else if (start_req || status_w1c) begin
            done_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register file and DMA registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dma_addr_q    <= '0;
            dma_len_q     <= '0;
            irq_en_q      <= 1'b0;
            lcd_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rd_addr_q     <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            avm_read_q    <= 1'b0;
        end else begin
            if (avs_write && (avs_address == A_DMA_ADDR)) begin
                dma_addr_q <= ADDR_W'(avs_writedata);
            end
            if (avs_write && (avs_address == A_DMA_LEN)) begin
                dma_len_q <= LEN_W'(avs_writedata);
            end
            if (ctrl_wr) begin
                irq_en_q  <= avs_writedata[1];
                lcd_rst_q <= avs_writedata[2];
            end
            busy_q        <= busy_d;
            done_q        <= done_d;
            rd_addr_q     <= rd_addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            avm_read_q    <= avm_read_d;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (avs_address)
            A_DMA_ADDR: rdata_d = 32'(dma_addr_q);
            A_DMA_LEN:  rdata_d = 32'(dma_len_q);
            A_CTRL:     rdata_d = {29'd0, lcd_rst_q, irq_en_q, 1'b0};
            A_STATUS:   rdata_d = {28'd0, fifo_full, fifo_empty, done_q, busy_q};
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avs_readdata_q <= '0;
        end else if (avs_read) begin
            avs_readdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_count_q <= fifo_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Writer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Writer FSM: next state. tmr counts down the remaining cycles of LOW/HIGH.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_LOW;
                tmr_d   = LOW_LOAD;
            end
            S_LOW: begin
                if (tmr_q == '0) begin
                    state_d = S_HIGH;
                    tmr_d   = HIGH_LOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_HIGH: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Writer FSM: outputs. The strobe is registered from the next state so
    // lcd_wr changes exactly on state boundaries and is glitch-free.
    always_comb begin
        fifo_pop = (state_q == S_IDLE) && !fifo_empty;
        wr_next  = (state_d != S_LOW);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lcd_wr_q   <= 1'b1;
            lcd_data_q <= '0;
            lcd_dc_q   <= 1'b0;
        end else begin
            lcd_wr_q <= wr_next;
            if (fifo_pop) begin
                lcd_data_q <= head_entry[DATA_W-1:0];
                lcd_dc_q   <= head_entry[DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign avs_readdata = avs_readdata_q;
    assign avm_address  = rd_addr_q;
    assign avm_read     = avm_read_q;
    assign lcd_data     = lcd_data_q;
    assign lcd_dc       = lcd_dc_q;
    assign lcd_rd       = 1'b1;
    assign lcd_wr       = lcd_wr_q;
    assign lcd_reset_n  = lcd_rst_q;
    assign irq          = done_q && irq_en_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_dma_8080.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_dma_8080
// Description : Self-checking bench for lcd_dma_8080. Register vectors are
//               table-driven; panel traffic is checked against an expected
//               write list built from the register/DMA rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_dma_8080;

    localparam int DATA_W      = 16;
    localparam int FIFO_DEPTH  = 16;
    localparam int ADDR_W      = 32;
    localparam int LEN_W       = 24;
    localparam int WR_LOW_CYC  = 2;
    localparam int WR_HIGH_CYC = 2;

    localparam logic [2:0] A_CMD = 3'd0, A_DATA = 3'd1, A_DADDR = 3'd2,
                           A_DLEN = 3'd3, A_CTRL = 3'd4, A_STAT = 3'd5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [2:0]        avs_address = '0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic              avs_read = 1'b0;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest = 1'b0;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic [DATA_W-1:0] lcd_data;
    logic              lcd_dc, lcd_rd, lcd_wr, lcd_reset_n, irq;

    always #5 clk = ~clk;

    lcd_dma_8080 #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .WR_LOW_CYC(WR_LOW_CYC), .WR_HIGH_CYC(WR_HIGH_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .lcd_data(lcd_data), .lcd_dc(lcd_dc), .lcd_rd(lcd_rd), .lcd_wr(lcd_wr),
        .lcd_reset_n(lcd_reset_n), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: the ordered list of panel writes the design owes us.
    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] seen[$];
    int              fall_times[$];

    // Slave memory model state and bookkeeping
    typedef struct {
        int              due;
        logic [DATA_W-1:0] data;
    } beat_t;
    beat_t pend[$];
    int cyc = 0;
    int n_accept = 0;
    int n_rdcyc = 0;
    int n_falls = 0;
    int occ_max = 0;
    int fall_cyc = 0;
    logic prev_wr = 1'b1;

    // Single negedge process: panel monitor plus Avalon read slave.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_wr = 1'b1;
        end else begin
            if (prev_wr && !lcd_wr) begin
                fall_cyc = cyc;
                n_falls++;
                fall_times.push_back(cyc);
            end
            if (!prev_wr && lcd_wr) begin
                check("wr_low_width", 32'(cyc - fall_cyc), 32'(WR_LOW_CYC));
                seen.push_back({lcd_dc, lcd_data});
            end
            prev_wr = lcd_wr;
        end
        // Random stall; a request seen now is accepted at the coming edge.
        avm_waitrequest = ($urandom_range(0, 3) == 0);
        if (avm_read) begin
            n_rdcyc++;
            if (!avm_waitrequest) begin
                beat_t b;
                b.due  = cyc + 1 + int'($urandom_range(0, 5));
                b.data = avm_address[DATA_W-1:0];
                pend.push_back(b);
                n_accept++;
            end
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend[0].data;
            void'(pend.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
        if (n_accept - n_falls > occ_max) occ_max = n_accept - n_falls;
    end

    // ---------------------------------------------------------------- tasks
    task automatic bus_write(input logic [2:0] a, input logic [31:0] v, input int budget,
                             output int waited);
        @(negedge clk);
        avs_address = a; avs_writedata = v; avs_write = 1'b1;
        #1;
        waited = 0;
        while (avs_waitrequest && waited < budget) begin
            @(negedge clk); #1;
            waited++;
        end
        if (waited >= budget) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%0d waited=%0d limit=%0d", a, waited, budget);
        end
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        int w;
        bus_write(a, v, 4000, w);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_irq(input string nm, input int budget);
        for (int k = 0; k < budget && !irq; k++) begin
            @(posedge clk); #2;
        end
        check({nm, "_irq"}, 32'(irq), 32'd1);
    endtask

    task automatic compare_frame(input string nm);
        check({nm, "_count"}, 32'(seen.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
            check($sformatf("%s_w%0d", nm, i), 32'(seen[i]), 32'(exp_q[i]));
        end
        seen.delete();
        exp_q.delete();
    endtask

    task automatic push_dma_exp(input logic [31:0] addr, input int len);
        for (int i = 0; i < len; i++) begin
            logic [31:0] a;
            a = addr + 32'(i * (DATA_W / 8));
            exp_q.push_back({1'b1, a[DATA_W-1:0]});
        end
    endtask

    task automatic run_frame(input string nm, input logic [31:0] addr, input int len);
        logic [31:0] st;
        wr(A_DADDR, addr);
        wr(A_DLEN, 32'(len));
        push_dma_exp(addr, len);
        n_accept = 0; n_falls = 0; occ_max = 0;
        wr(A_CTRL, 32'h7);
        wait_irq(nm, len * 20 + 300);
        // irq only after the last strobe rise: every word already on the panel
        check({nm, "_writes_at_irq"}, 32'(seen.size()), 32'(exp_q.size()));
        // FIFO + outstanding <= depth; +2 covers the word held by the writer
        // and acceptance being counted half a cycle early.
        check({nm, "_occupancy"}, 32'(occ_max <= FIFO_DEPTH + 2), 32'd1);
        compare_frame(nm);
        wr(A_STAT, 32'h2);
        @(posedge clk); #2;
        check({nm, "_irq_cleared"}, 32'(irq), 32'd0);
        rd(A_STAT, st);
        check({nm, "_status_after_w1c"}, st, 32'h4);
    endtask

    // Register access vectors
    typedef struct {
        logic        do_wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[12];

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] d, s1, s2;
        int          waited, nseen;

        vt[0]  = '{1'b0, A_STAT,  32'h0,        32'h4};
        vt[1]  = '{1'b0, A_CTRL,  32'h0,        32'h0};
        vt[2]  = '{1'b0, A_DADDR, 32'h0,        32'h0};
        vt[3]  = '{1'b0, A_DLEN,  32'h0,        32'h0};
        vt[4]  = '{1'b1, A_DADDR, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[5]  = '{1'b1, A_DLEN,  32'hFFABCDEF, 32'h00ABCDEF};
        vt[6]  = '{1'b1, A_CTRL,  32'h6,        32'h6};
        vt[7]  = '{1'b0, 3'd6,    32'h0,        32'h0};
        vt[8]  = '{1'b0, 3'd7,    32'h0,        32'h0};
        vt[9]  = '{1'b1, A_CTRL,  32'h2,        32'h2};
        vt[10] = '{1'b1, A_STAT,  32'hF,        32'h4};
        vt[11] = '{1'b1, A_CTRL,  32'h6,        32'h6};

        // ---- 1: reset state
        do_reset();
        @(posedge clk); #2;
        check("rst_lcd_wr", 32'(lcd_wr), 32'd1);
        check("rst_lcd_rd", 32'(lcd_rd), 32'd1);
        check("rst_lcd_reset_n", 32'(lcd_reset_n), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_avm_read", 32'(avm_read), 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (vt[i].do_wr) wr(vt[i].addr, vt[i].wdata);
            rd(vt[i].addr, d);
            check($sformatf("regvec%0d", i), d, vt[i].exp);
        end
        check("ctrl_lcd_reset_n", 32'(lcd_reset_n), 32'd1);

        // ---- 2: host CMD then DATA
        fall_times.delete();
        wr(A_CMD, 32'hFFFF002C);
        exp_q.push_back({1'b0, 16'h002C});
        wr(A_DATA, 32'h00001234);
        exp_q.push_back({1'b1, 16'h1234});
        for (int k = 0; k < 100 && seen.size() < 2; k++) begin
            @(posedge clk); #2;
        end
        if (fall_times.size() >= 2)
            check("host_write_spacing", 32'(fall_times[1] - fall_times[0]),
                  32'(1 + WR_LOW_CYC + WR_HIGH_CYC + 1));
        else
            check("host_write_falls", 32'(fall_times.size()), 32'd2);
        compare_frame("host");

        // ---- 3: 40-word DMA frame, then randomized frames
        run_frame("dma40", 32'h100, 40);
        for (int r = 0; r < 3; r++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 32'h7FFF)) * 32'd2;
            if ($urandom_range(0, 1) == 1) begin
                logic [15:0] cw;
                cw = 16'($urandom);
                wr(A_CMD, {16'h0, cw});
                exp_q.push_back({1'b0, cw});
            end
            run_frame($sformatf("rnd%0d", r), ra, int'($urandom_range(1, 24)));
        end

        // ---- 4: zero-length DMA
        wr(A_DLEN, 32'h0);
        n_rdcyc = 0;
        wr(A_CTRL, 32'h7);
        rd(A_STAT, s1);
        rd(A_STAT, s2);
        check("len0_status_second", s2, 32'h6);
        check("len0_no_reads", 32'(n_rdcyc), 32'd0);
        check("len0_irq", 32'(irq), 32'd1);
        wr(A_STAT, 32'h2);
        rd(A_STAT, d);
        check("len0_w1c", d, 32'h4);

        // ---- 5: CMD write stalls during an active frame
        wr(A_DADDR, 32'h400);
        wr(A_DLEN, 32'd20);
        push_dma_exp(32'h400, 20);
        wr(A_CTRL, 32'h7);
        bus_write(A_CMD, 32'hAB, 4000, waited);
        nseen = seen.size();
        exp_q.push_back({1'b0, 16'h00AB});
        check("stall_waited", 32'(waited > 0), 32'd1);
        check("stall_frame_done_first", 32'(nseen), 32'd20);
        rd(A_STAT, d);
        check("stall_done_bit", d & 32'h3, 32'h2);
        for (int k = 0; k < 100 && seen.size() < 21; k++) begin
            @(posedge clk); #2;
        end
        compare_frame("stall");
        wr(A_STAT, 32'h2);

        // ---- 6: reset mid-frame with reads in flight
        wr(A_DADDR, 32'h800);
        wr(A_DLEN, 32'd30);
        push_dma_exp(32'h800, 30);
        n_accept = 0;
        wr(A_CTRL, 32'h7);
        for (int k = 0; k < 500 && !(n_accept >= 8 && pend.size() > 0); k++) begin
            @(posedge clk); #2;
        end
        check("midrst_reads_in_flight", 32'(pend.size() > 0), 32'd1);
        do_reset();
        #1;
        check("midrst_lcd_wr", 32'(lcd_wr), 32'd1);
        check("midrst_avm_read", 32'(avm_read), 32'd0);
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
            check($sformatf("midrst_prefix%0d", i), 32'(seen[i]), 32'(exp_q[i]));
        end
        seen.delete();
        exp_q.delete();
        rd(A_STAT, d);
        check("midrst_status", d, 32'h4);
        rd(A_DADDR, d);
        check("midrst_dma_addr", d, 32'h0);
        repeat (12) @(posedge clk);
        #2;
        rd(A_STAT, d);
        check("late_beats_ignored_status", d, 32'h4);
        check("late_beats_no_writes", 32'(seen.size()), 32'd0);
        run_frame("fresh", 32'h2000, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
